channel_ccw_sequencer: RTL and testbench
========================================

// Module: channel_ccw_sequencer
// PURPOSE
//  Executes a chain of 64-bit channel command words (CCWs) against the parallel-channel core without CPU involvement.
//  Fetches each CCW from system memory over a single-beat 64-bit AXI read port.
//  Programs the core's address/command/count and DMA address, pulses start, waits for the operation to end, then evaluates status.
//  Sits between the AXI-lite register block (which supplies start, CCW pointer and device address) and the channel core / byte DMA.
// PARAMETERS
//  MAX_CHAIN   255   max CCWs per chain; exceeding it -> err 6
// PORTS
//  aclk            in   1   clock
//  aresetn         in   1   synchronous active-low reset
//  start           in   1   1-cycle pulse: begin chain; ignored while busy
//  halt            in   1   level/pulse: stop chain at next safe point
//  ccw_addr        in   32  address of first CCW (8-byte aligned)
//  dev_addr        in   8   device address used for every CCW of the chain
//  busy            out  1   chain in progress
//  done            out  1   1-cycle pulse when chain ends (ok or error)
//  err_code        out  3   0 ok,1 AXI rresp,2 unit check/bad status,3 incorrect length,4 zero count,5 halted,6 chain limit,7 misaligned
//  last_status     out  8   status byte of last executed CCW
//  last_res_count  out  8   residual count of last executed CCW
//  ccw_ptr         out  32  address of CCW being / last executed
//  ccw_executed    out  8   number of CCWs completed this chain
//  m_axi_ar{valid,ready,addr[31:0]}, m_axi_r{valid,ready,data[63:0],resp[1:0]}   CCW fetch port
//  ch_address/ch_command/ch_count  out 8 each; ch_dma_addr out 32; ch_start out 1 (pulse)
//  ch_active  in 1;  ch_status  in 8;  ch_res_count  in 8
// BEHAVIOUR
//  CCW format: [63:56] command, [55:48] flags (b7 CC chain, b6 SLI suppress length), [47:40] count, [39:32] rsvd, [31:0] data addr.
//  Status good = CE(b3) & DE(b2) set, UC(b1) & UE(b0) clear.
//  Reset: state IDLE; all outputs 0 (err_code 0, ptr 0, arvalid/rready 0, ch_start 0).
//  IDLE: start -> if ccw_addr[2:0]!=0: done, err 7, next cycle; else latch ccw_addr/dev_addr, clear ccw_executed, busy=1 -> FETCH_AR.
//  FETCH_AR: arvalid=1, araddr=ccw_ptr; on arready -> FETCH_R.
//  FETCH_R: rready=1; on rvalid: rresp!=0 -> err 1; count==0 -> err 4; else latch CCW -> ISSUE.
//  ISSUE: drive ch_* fields, ch_start high exactly 1 cycle -> SETTLE.
//  SETTLE: one cycle unconditionally (core raises active within 1 cycle of start) -> RUN.
//  RUN: wait ch_active==0; capture last_status/last_res_count; ccw_executed++ -> EVAL.
//  EVAL (priority order): bad status -> err 2; res_count!=0 & !SLI -> err 3; halt seen -> err 5;
//   !CC -> err 0; ccw_executed==MAX_CHAIN -> err 6; else ccw_ptr+=8 (mod 2^32 wrap) -> FETCH_AR.
//  Ending: done pulses 1 cycle in the END cycle, busy drops the same cycle, err_code/last_* hold until next start.
//  Halt: sticky-latched while busy. Never aborts an AXI handshake or a running core op.
//   In FETCH_*: finish read, then end with err 5 without issuing. In ISSUE/SETTLE/RUN: finish op, then end err 5.
//  start coincident with halt in IDLE: start accepted, halt ignored.
//  Latency: start -> arvalid 1 cycle. rvalid -> ch_start 1 cycle. ch_active fall -> next arvalid 2 cycles.
//  aresetn mid-chain: immediate return to IDLE, no done pulse; the AXI peer shares aresetn.
// STRUCTURE
//  channel_pkg: CCW field offsets, flag bits CC/SLI, status bit positions, err_code enum, state enum.
//  No sub-modules: fetch handshake is two states of the main FSM.
// TESTING
//  1 CCW {cmd 02, flags 00, cnt 4, addr 1000} at 0x100, core status 0C res 0 -> ch_start once, done, err 0, executed 1.
//  3-CCW chain at 0x200, CC on first two -> araddr 200,208,210; executed 3; ccw_ptr 0x210; err 0.
//  2nd CCW status 0E (UC) -> chain stops after 2, err 2, last_status 0E, no 3rd fetch.
//  res_count 3: SLI clear -> err 3; SLI set and CC set -> chain continues.
//  rresp=2 on fetch -> err 1, no ch_start. ccw_addr 0x104 -> err 7 without AR. count 0 -> err 4.
//  halt pulse mid-RUN -> op completes, no further arvalid, err 5. start while busy ignored. MAX_CHAIN=2 with 3 CC CCWs -> err 6.

Source files
------------

// File: rtl/channel_ccw_sequencer_pkg.sv
// Shared definitions for the channel CCW sequencer: the layout of a channel
// command word, flag and status bit positions, error codes and FSM states.
package channel_ccw_sequencer_pkg;

    // CCW layout (64-bit word, big-field-first)
    localparam int CCW_CMD_LSB   = 56;
    localparam int CCW_FLAGS_LSB = 48;
    localparam int CCW_COUNT_LSB = 40;
    localparam int CCW_RSVD_LSB  = 32;
    localparam int CCW_ADDR_LSB  = 0;

    // Bit positions inside the flags byte
    localparam int FLAG_CC  = 7;   // command chaining
    localparam int FLAG_SLI = 6;   // suppress incorrect-length indication

    // Bit positions inside the device status byte
    localparam int ST_CE = 3;      // channel end
    localparam int ST_DE = 2;      // device end
    localparam int ST_UC = 1;      // unit check
    localparam int ST_UE = 0;      // unit exception

    typedef enum logic [2:0] {
        ERR_OK          = 3'd0,
        ERR_RRESP       = 3'd1,
        ERR_STATUS      = 3'd2,
        ERR_LENGTH      = 3'd3,
        ERR_ZERO_COUNT  = 3'd4,
        ERR_HALTED      = 3'd5,
        ERR_CHAIN_LIMIT = 3'd6,
        ERR_MISALIGNED  = 3'd7
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_AR = 3'd1,
        S_FETCH_R  = 3'd2,
        S_ISSUE    = 3'd3,
        S_SETTLE   = 3'd4,
        S_RUN      = 3'd5,
        S_EVAL     = 3'd6,
        S_END      = 3'd7
    } state_e;

    // A CCW completed cleanly when both channel end and device end are
    // reported and neither unit check nor unit exception is present.
    function automatic logic status_good(input logic [7:0] st);
        return st[ST_CE] & st[ST_DE] & ~st[ST_UC] & ~st[ST_UE];
    endfunction

endpackage

// File: rtl/channel_ccw_sequencer_if.sv
// Single-beat 64-bit AXI read channel used to fetch CCWs from memory.
// master: the sequencer issuing reads; slave: the memory side.
interface channel_ccw_sequencer_if;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/channel_ccw_sequencer.sv
// Channel CCW sequencer: walks a chain of channel command words in memory,
// programs the parallel-channel core for each one, waits for the operation
// to finish and decides from the ending status whether to continue the chain.
module channel_ccw_sequencer
    import channel_ccw_sequencer_pkg::*;
#(
    parameter int unsigned MAX_CHAIN = 255
) (
    input  logic        aclk,
    input  logic        aresetn,

    // control from the register block
    input  logic        start_i,
    input  logic        halt_i,
    input  logic [31:0] ccw_addr_i,
    input  logic [7:0]  dev_addr_i,

    // chain status back to the register block
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  err_code_o,
    output logic [7:0]  last_status_o,
    output logic [7:0]  last_res_count_o,
    output logic [31:0] ccw_ptr_o,
    output logic [7:0]  ccw_executed_o,

    // CCW fetch port
    channel_ccw_sequencer_if.master axi,

    // channel core / byte DMA programming
    output logic [7:0]  ch_address_o,
    output logic [7:0]  ch_command_o,
    output logic [7:0]  ch_count_o,
    output logic [31:0] ch_dma_addr_o,
    output logic        ch_start_o,
    input  logic        ch_active_i,
    input  logic [7:0]  ch_status_i,
    input  logic [7:0]  ch_res_count_i
);

    state_e      state_q, state_d;
    err_e        end_err;
    err_e        err_q;

    logic [31:0] ptr_q;
    logic [7:0]  dev_q;
    logic [7:0]  cmd_q;
    logic [7:0]  count_q;
    logic [31:0] daddr_q;
    logic        cc_q;
    logic        sli_q;
    logic [7:0]  exec_q;
    logic [7:0]  status_q;
    logic [7:0]  res_q;
    logic        halt_q;

    logic        halt_seen;
    logic        addr_misaligned;
    logic        limit_hit;
    logic [7:0]  fetch_count;
    logic        unused_rdata;

    // A halt raised in the same cycle as the decision still counts.
    assign halt_seen       = halt_q | halt_i;
    assign addr_misaligned = (ccw_addr_i[2:0] != 3'b000);
    assign limit_hit       = (32'(exec_q) == MAX_CHAIN);
    assign fetch_count     = axi.rdata[CCW_COUNT_LSB +: 8];

    // Reserved byte and the undefined flag bits carry no meaning here.
    assign unused_rdata = ^{axi.rdata[CCW_RSVD_LSB +: 8], axi.rdata[CCW_FLAGS_LSB +: 6]};

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; end_err is the code reported when entering S_END
    always_comb begin
        state_d = state_q;
        end_err = ERR_OK;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (addr_misaligned) begin
                        state_d = S_END;
                        end_err = ERR_MISALIGNED;
                    end else begin
                        state_d = S_FETCH_AR;
                    end
                end
            end
            S_FETCH_AR: begin
                if (axi.arready) begin
                    state_d = S_FETCH_R;
                end
            end
            S_FETCH_R: begin
                // The read always completes before a halt is honoured.
                if (axi.rvalid) begin
                    if (axi.rresp != 2'b00) begin
                        state_d = S_END;
                        end_err = ERR_RRESP;
                    end else if (fetch_count == 8'd0) begin
                        state_d = S_END;
                        end_err = ERR_ZERO_COUNT;
                    end else if (halt_seen) begin
                        state_d = S_END;
                        end_err = ERR_HALTED;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Gives the core its cycle to raise active after start.
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!ch_active_i) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_END;
                if (!status_good(status_q)) begin
                    end_err = ERR_STATUS;
                end else if ((res_q != 8'd0) && !sli_q) begin
                    end_err = ERR_LENGTH;
                end else if (halt_seen) begin
                    end_err = ERR_HALTED;
                end else if (!cc_q) begin
                    end_err = ERR_OK;
                end else if (limit_hit) begin
                    end_err = ERR_CHAIN_LIMIT;
                end else begin
                    state_d = S_FETCH_AR;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        ch_start_o  = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE:     busy_o = 1'b0;
            S_FETCH_AR: axi.arvalid = 1'b1;
            S_FETCH_R:  axi.rready  = 1'b1;
            S_ISSUE:    ch_start_o  = 1'b1;
            S_END: begin
                busy_o = 1'b0;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Chain bookkeeping: pointer, latched CCW, completion status and error
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_q    <= ERR_OK;
            ptr_q    <= '0;
            dev_q    <= '0;
            cmd_q    <= '0;
            count_q  <= '0;
            daddr_q  <= '0;
            cc_q     <= 1'b0;
            sli_q    <= 1'b0;
            exec_q   <= '0;
            status_q <= '0;
            res_q    <= '0;
            halt_q   <= 1'b0;
        end else begin
            // Halt only matters once a chain is running; a halt arriving
            // together with start is deliberately dropped.
            if (state_q == S_IDLE) begin
                halt_q <= 1'b0;
            end else if (busy_o && halt_i) begin
                halt_q <= 1'b1;
            end

            if (state_d == S_END) begin
                err_q <= end_err;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i && !addr_misaligned) begin
                        ptr_q    <= ccw_addr_i;
                        dev_q    <= dev_addr_i;
                        exec_q   <= '0;
                        status_q <= '0;
                        res_q    <= '0;
                        err_q    <= ERR_OK;
                    end
                end
                S_FETCH_R: begin
                    if (axi.rvalid && (axi.rresp == 2'b00)) begin
                        cmd_q   <= axi.rdata[CCW_CMD_LSB +: 8];
                        cc_q    <= axi.rdata[CCW_FLAGS_LSB + FLAG_CC];
                        sli_q   <= axi.rdata[CCW_FLAGS_LSB + FLAG_SLI];
                        count_q <= axi.rdata[CCW_COUNT_LSB +: 8];
                        daddr_q <= axi.rdata[CCW_ADDR_LSB +: 32];
                    end
                end
                S_RUN: begin
                    if (!ch_active_i) begin
                        status_q <= ch_status_i;
                        res_q    <= ch_res_count_i;
                        exec_q   <= exec_q + 8'd1;
                    end
                end
                S_EVAL: begin
                    // Next CCW sits directly after this one; 32-bit wrap.
                    if (state_d == S_FETCH_AR) begin
                        ptr_q <= ptr_q + 32'd8;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi.araddr       = ptr_q;
    assign err_code_o       = err_q;
    assign last_status_o    = status_q;
    assign last_res_count_o = res_q;
    assign ccw_ptr_o        = ptr_q;
    assign ccw_executed_o   = exec_q;

    assign ch_address_o     = dev_q;
    assign ch_command_o     = cmd_q;
    assign ch_count_o       = count_q;
    assign ch_dma_addr_o    = daddr_q;

endmodule

// File: tb/tb_channel_ccw_sequencer.sv
// Bench for channel_ccw_sequencer: a table of complete chains plus a few
// hand-written timing/halt/reset sequences. A second instance built with
// MAX_CHAIN=2 runs in lockstep on the same responses.
module tb_channel_ccw_sequencer;
    import channel_ccw_sequencer_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] ccw_addr = '0;
    logic [7:0]  dev_addr = '0;

    logic        busy, done, ch_start;
    logic [2:0]  err;
    logic [7:0]  last_st, last_rc, exec_n, ch_addr, ch_cmd, ch_cnt;
    logic [31:0] ptr, ch_dma;

    logic        busy_b, done_b, ch_start_b;
    logic [2:0]  err_b;
    logic [7:0]  last_st_b, last_rc_b, exec_b, ch_addr_b, ch_cmd_b, ch_cnt_b;
    logic [31:0] ptr_b, ch_dma_b;

    logic        ch_active = 1'b0;
    logic [7:0]  ch_status = '0;
    logic [7:0]  ch_res = '0;

    channel_ccw_sequencer_if axi_a ();
    channel_ccw_sequencer_if axi_b ();

    assign axi_b.arready = axi_a.arready;
    assign axi_b.rvalid  = axi_a.rvalid;
    assign axi_b.rdata   = axi_a.rdata;
    assign axi_b.rresp   = axi_a.rresp;

    always #5 aclk = ~aclk;

    channel_ccw_sequencer #(.MAX_CHAIN(255)) dut (
        .aclk(aclk), .aresetn(aresetn), .start_i(start), .halt_i(halt),
        .ccw_addr_i(ccw_addr), .dev_addr_i(dev_addr),
        .busy_o(busy), .done_o(done), .err_code_o(err),
        .last_status_o(last_st), .last_res_count_o(last_rc),
        .ccw_ptr_o(ptr), .ccw_executed_o(exec_n), .axi(axi_a),
        .ch_address_o(ch_addr), .ch_command_o(ch_cmd), .ch_count_o(ch_cnt),
        .ch_dma_addr_o(ch_dma), .ch_start_o(ch_start),
        .ch_active_i(ch_active), .ch_status_i(ch_status), .ch_res_count_i(ch_res)
    );

    channel_ccw_sequencer #(.MAX_CHAIN(2)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .start_i(start), .halt_i(halt),
        .ccw_addr_i(ccw_addr), .dev_addr_i(dev_addr),
        .busy_o(busy_b), .done_o(done_b), .err_code_o(err_b),
        .last_status_o(last_st_b), .last_res_count_o(last_rc_b),
        .ccw_ptr_o(ptr_b), .ccw_executed_o(exec_b), .axi(axi_b),
        .ch_address_o(ch_addr_b), .ch_command_o(ch_cmd_b), .ch_count_o(ch_cnt_b),
        .ch_dma_addr_o(ch_dma_b), .ch_start_o(ch_start_b),
        .ch_active_i(ch_active), .ch_status_i(ch_status), .ch_res_count_i(ch_res)
    );

    // ---------------- memory, core and event monitors ----------------
    logic [63:0] mem [logic [31:0]];
    int          done_total = 0, b_done_total = 0, ar_total = 0, fetch_total = 0, op_total = 0;
    logic [31:0] ar_log [64];
    logic [7:0]  op_cmd [64];
    logic [7:0]  op_cnt [64];
    logic [7:0]  op_dev [64];
    logic [31:0] op_dma [64];
    logic [31:0] ar_lat = '0;
    int          bad_abs = -1;
    int          op_base = 0;
    logic [7:0]  cur_st [4];
    logic [7:0]  cur_rc [4];
    int          core_cnt = 0, run_idx = 0;

    initial axi_a.arready = 1'b1;
    initial begin
        axi_a.rvalid = 1'b0;
        axi_a.rdata  = '0;
        axi_a.rresp  = '0;
    end

    always @(negedge aclk) begin
        if (done)   done_total++;
        if (done_b) b_done_total++;
        if (axi_a.arvalid && axi_a.arready) begin
            ar_log[ar_total % 64] = axi_a.araddr;
            ar_lat = axi_a.araddr;
            ar_total++;
        end
        if (axi_a.rready) begin
            axi_a.rvalid = 1'b1;
            axi_a.rdata  = mem.exists(ar_lat) ? mem[ar_lat] : 64'h0;
            axi_a.rresp  = (fetch_total == bad_abs) ? 2'b10 : 2'b00;
        end else begin
            if (axi_a.rvalid) fetch_total++;
            axi_a.rvalid = 1'b0;
            axi_a.rresp  = 2'b00;
        end
    end

    always @(negedge aclk) begin
        if (ch_start) begin
            op_cmd[op_total % 64] = ch_cmd;
            op_cnt[op_total % 64] = ch_cnt;
            op_dev[op_total % 64] = ch_addr;
            op_dma[op_total % 64] = ch_dma;
            run_idx   = (op_total - op_base) & 3;
            op_total++;
            ch_active = 1'b1;
            core_cnt  = 3;
            ch_status = 8'h00;
            ch_res    = 8'h00;
        end else if (ch_active) begin
            core_cnt--;
            if (core_cnt == 0) begin
                ch_active = 1'b0;
                ch_status = cur_st[run_idx];
                ch_res    = cur_rc[run_idx];
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [63:0] c0, c1, c2;
        logic [7:0]  s0, s1, s2, r0, r1, r2;
        int          badf;
        logic [2:0]  e_err;
        logic [7:0]  e_exec, e_st, e_rc;
        logic [31:0] e_ptr;
        int          e_starts, e_ars;
        logic        chk_data;
        logic [2:0]  b_err;
        logic [7:0]  b_exec;
    } vec_t;

    vec_t vecs [8];
    int   s_done, s_bdone, s_ar, s_op;

    task automatic load_vec(input int i);
        vec_t v;
        v = vecs[i];
        mem[v.base]       = v.c0;
        mem[v.base + 8]   = v.c1;
        mem[v.base + 16]  = v.c2;
        cur_st[0] = v.s0; cur_st[1] = v.s1; cur_st[2] = v.s2; cur_st[3] = 8'h0C;
        cur_rc[0] = v.r0; cur_rc[1] = v.r1; cur_rc[2] = v.r2; cur_rc[3] = 8'h00;
        op_base = op_total;
        bad_abs = (v.badf < 0) ? -1 : fetch_total + v.badf;
        s_done  = done_total;
        s_bdone = b_done_total;
        s_ar    = ar_total;
        s_op    = op_total;
    endtask

    task automatic start_chain(input logic [31:0] a);
        ccw_addr = a;
        dev_addr = 8'h5A;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300; k++) begin
            if (done_total > s_done) break;
            tick();
        end
        chk({name, "_done_seen"}, 64'(done_total > s_done), 1);
    endtask

    task automatic wait_op();
        for (int k = 0; k < 100; k++) begin
            if (op_total > s_op) break;
            tick();
        end
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string n;
        v = vecs[i];
        n = $sformatf("v%0d", i);
        load_vec(i);
        start_chain(v.base);
        wait_done(n);
        tick();
        tick();
        chk({n, "_err"}, err, v.e_err);
        chk({n, "_done_pulses"}, done_total - s_done, 1);
        chk({n, "_busy_after"}, busy, 0);
        chk({n, "_ar_count"}, ar_total - s_ar, v.e_ars);
        chk({n, "_start_count"}, op_total - s_op, v.e_starts);
        for (int k = 0; k < v.e_ars; k++)
            chk($sformatf("%s_araddr%0d", n, k), ar_log[(s_ar + k) % 64], v.base + 32'(8 * k));
        if (v.chk_data) begin
            chk({n, "_executed"}, exec_n, v.e_exec);
            chk({n, "_last_status"}, last_st, v.e_st);
            chk({n, "_last_res"}, last_rc, v.e_rc);
            chk({n, "_ccw_ptr"}, ptr, v.e_ptr);
            chk({n, "_b_executed"}, exec_b, v.b_exec);
        end
        if (v.e_starts > 0) begin
            chk({n, "_ch_command"}, op_cmd[s_op % 64], v.c0[63:56]);
            chk({n, "_ch_count"}, op_cnt[s_op % 64], v.c0[47:40]);
            chk({n, "_ch_dma"}, op_dma[s_op % 64], v.c0[31:0]);
            chk({n, "_ch_address"}, op_dev[s_op % 64], 8'h5A);
        end
        chk({n, "_b_err"}, err_b, v.b_err);
        chk({n, "_b_done_pulses"}, b_done_total - s_bdone, 1);
    endtask

    initial begin
        vecs[0] = '{base:32'h100, c0:64'h0200_0400_0000_1000, c1:64'h0, c2:64'h0,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h0, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd0, e_exec:8'd1, e_st:8'h0C, e_rc:8'h0, e_ptr:32'h100,
                    e_starts:1, e_ars:1, chk_data:1'b1, b_err:3'd0, b_exec:8'd1};
        vecs[1] = '{base:32'h200, c0:64'h0180_0800_0000_2000, c1:64'h0280_1000_0000_3000,
                    c2:64'h0300_0200_0000_4000,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h0, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd0, e_exec:8'd3, e_st:8'h0C, e_rc:8'h0, e_ptr:32'h210,
                    e_starts:3, e_ars:3, chk_data:1'b1, b_err:3'd6, b_exec:8'd2};
        vecs[2] = '{base:32'h300, c0:64'h0180_0800_0000_2000, c1:64'h0280_1000_0000_3000,
                    c2:64'h0300_0200_0000_4000,
                    s0:8'h0C, s1:8'h0E, s2:8'h0C, r0:8'h0, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd2, e_exec:8'd2, e_st:8'h0E, e_rc:8'h0, e_ptr:32'h308,
                    e_starts:2, e_ars:2, chk_data:1'b1, b_err:3'd2, b_exec:8'd2};
        vecs[3] = '{base:32'h400, c0:64'h0200_0400_0000_1000, c1:64'h0, c2:64'h0,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h03, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd3, e_exec:8'd1, e_st:8'h0C, e_rc:8'h03, e_ptr:32'h400,
                    e_starts:1, e_ars:1, chk_data:1'b1, b_err:3'd3, b_exec:8'd1};
        vecs[4] = '{base:32'h500, c0:64'h02C0_0400_0000_1000, c1:64'h0300_0400_0000_5000, c2:64'h0,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h03, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd0, e_exec:8'd2, e_st:8'h0C, e_rc:8'h0, e_ptr:32'h508,
                    e_starts:2, e_ars:2, chk_data:1'b1, b_err:3'd0, b_exec:8'd2};
        vecs[5] = '{base:32'h600, c0:64'h0200_0400_0000_1000, c1:64'h0, c2:64'h0,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h0, r1:8'h0, r2:8'h0, badf:0,
                    e_err:3'd1, e_exec:8'd0, e_st:8'h0, e_rc:8'h0, e_ptr:32'h600,
                    e_starts:0, e_ars:1, chk_data:1'b1, b_err:3'd1, b_exec:8'd0};
        vecs[6] = '{base:32'h104, c0:64'h0200_0400_0000_1000, c1:64'h0, c2:64'h0,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h0, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd7, e_exec:8'd0, e_st:8'h0, e_rc:8'h0, e_ptr:32'h0,
                    e_starts:0, e_ars:0, chk_data:1'b0, b_err:3'd7, b_exec:8'd0};
        vecs[7] = '{base:32'h700, c0:64'h0200_0000_0000_1000, c1:64'h0, c2:64'h0,
                    s0:8'h0C, s1:8'h0C, s2:8'h0C, r0:8'h0, r1:8'h0, r2:8'h0, badf:-1,
                    e_err:3'd4, e_exec:8'd0, e_st:8'h0, e_rc:8'h0, e_ptr:32'h700,
                    e_starts:0, e_ars:1, chk_data:1'b1, b_err:3'd4, b_exec:8'd0};

        // reset state
        aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ptr", ptr, 0);
        chk("rst_executed", exec_n, 0);
        chk("rst_arvalid", axi_a.arvalid, 0);
        chk("rst_rready", axi_a.rready, 0);
        chk("rst_ch_start", ch_start, 0);
        chk("rst_last_status", last_st, 0);
        chk("rst_ch_dma", ch_dma, 0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // latency: start->arvalid 1, rvalid->ch_start 1, active fall->arvalid 2
        load_vec(4);
        start_chain(32'h500);
        chk("lat_start_ar", axi_a.arvalid, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (axi_a.rvalid && axi_a.rready) break;
        end
        tick();
        chk("lat_r_chstart", ch_start, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!ch_active) break;
        end
        tick();
        chk("lat_fall_ar_early", axi_a.arvalid, 0);
        tick();
        chk("lat_fall_ar", axi_a.arvalid, 1);
        wait_done("lat");
        tick();
        chk("lat_err", err, 0);

        // halt pulse while the core runs: op finishes, chain stops
        load_vec(1);
        start_chain(32'h200);
        wait_op();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done("halt_run");
        tick();
        tick();
        chk("halt_run_err", err, 5);
        chk("halt_run_executed", exec_n, 1);
        chk("halt_run_starts", op_total - s_op, 1);
        chk("halt_run_ars", ar_total - s_ar, 1);
        chk("halt_run_b_err", err_b, 5);

        // start together with halt in IDLE: halt ignored
        load_vec(0);
        ccw_addr = 32'h100;
        start = 1'b1;
        halt  = 1'b1;
        tick();
        start = 1'b0;
        halt  = 1'b0;
        wait_done("start_halt");
        tick();
        chk("start_halt_err", err, 0);
        chk("start_halt_executed", exec_n, 1);

        // halt during fetch: read completes, nothing issued
        load_vec(0);
        start_chain(32'h100);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done("halt_fetch");
        tick();
        chk("halt_fetch_err", err, 5);
        chk("halt_fetch_starts", op_total - s_op, 0);
        chk("halt_fetch_ars", ar_total - s_ar, 1);

        // start while busy is ignored
        load_vec(0);
        start_chain(32'h100);
        wait_op();
        start_chain(32'h104);
        wait_done("busy_start");
        repeat (5) tick();
        chk("busy_start_err", err, 0);
        chk("busy_start_ptr", ptr, 32'h100);
        chk("busy_start_done_pulses", done_total - s_done, 1);

        // reset mid-chain: straight to idle, no done pulse
        load_vec(1);
        start_chain(32'h200);
        wait_op();
        aresetn = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_ptr", ptr, 0);
        chk("midrst_executed", exec_n, 0);
        aresetn = 1'b1;
        repeat (10) tick();
        chk("midrst_no_done", done_total - s_done, 0);
        chk("midrst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
